// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster
//   Completion-side producer of the common data bus. Each functional unit
//   has a small FIFO of finished results. A round-robin arbiter picks one
//   non-empty FIFO per cycle and broadcasts its head on the CDB.
//
// Ports
//   clock            system clock, all state changes on the rising edge
//   reset            synchronous active-low reset (0 = reset)
//   squash           ROB mispredict flush; empties every FIFO
//   fu_valid         per unit: a completed result is presented
//   fu_tag           per unit ROB tag, slice [i*TAG_W +: TAG_W]
//   fu_value         per unit result value, slice [i*XLEN +: XLEN]
//   fu_take_branch   per unit resolved branch-taken flag
//   fu_ready         per unit: the FIFO can accept a result this cycle
//   cdb_valid        CDB carries a broadcast this cycle
//   cdb_tag          broadcast ROB tag (0 when idle)
//   cdb_value        broadcast value (0 when idle)
//   cdb_take_branch  broadcast branch outcome (0 when idle)
//   cdb_fu_idx       unit that sourced the broadcast (0 when idle)
module cdb_broadcaster #(
  parameter int NUM_FU    = 4,
  parameter int BUF_DEPTH = 2,
  parameter int TAG_W     = 5,
  parameter int XLEN      = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        squash,
  input  logic [NUM_FU-1:0]           fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]     fu_tag,
  input  logic [NUM_FU*XLEN-1:0]      fu_value,
  input  logic [NUM_FU-1:0]           fu_take_branch,
  output logic [NUM_FU-1:0]           fu_ready,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [XLEN-1:0]             cdb_value,
  output logic                        cdb_take_branch,
  output logic [$clog2(NUM_FU)-1:0]   cdb_fu_idx
);

  localparam int IDX_W = $clog2(NUM_FU);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  // Heads of every FIFO, gathered for the output mux.
  logic [TAG_W-1:0] head_tag   [NUM_FU];
  logic [XLEN-1:0]  head_value [NUM_FU];
  logic             head_br    [NUM_FU];
  logic [NUM_FU-1:0] nonempty;

  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] rr_ptr_reg;
  logic [IDX_W-1:0] rr_ptr_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------
  // Per-unit result FIFOs
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
    logic [TAG_W-1:0] tag_mem   [BUF_DEPTH];
    logic [XLEN-1:0]  value_mem [BUF_DEPTH];
    logic             br_mem    [BUF_DEPTH];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push;
    logic             pop;

    // Ready deliberately ignores a same-cycle pop so it never depends on
    // the arbiter outcome.
    assign fu_ready[gi] = reset & ~squash & (count_reg < CNT_W'(BUF_DEPTH));
    assign push         = fu_valid[gi] & fu_ready[gi];
    assign pop          = grant_valid & (grant_idx == IDX_W'(gi));
    assign nonempty[gi] = (count_reg != '0);

    assign head_tag[gi]   = tag_mem[head_reg];
    assign head_value[gi] = value_mem[head_reg];
    assign head_br[gi]    = br_mem[head_reg];

    // Storage has no reset; push is already gated by reset and squash.
    always_ff @(posedge clock) begin
      if (push) begin
        tag_mem[tail_reg]   <= fu_tag[gi*TAG_W +: TAG_W];
        value_mem[tail_reg] <= fu_value[gi*XLEN +: XLEN];
        br_mem[tail_reg]    <= fu_take_branch[gi];
      end
    end

    always_ff @(posedge clock) begin
      if (!reset || squash) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        if (push) tail_reg <= ptr_inc(tail_reg);
        if (pop)  head_reg <= ptr_inc(head_reg);
        case ({push, pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Round-robin arbiter: first non-empty unit starting at rr_ptr.
  // NUM_FU is a power of two, so the index wraps by plain overflow.
  // ---------------------------------------------------------------------
  always_comb begin
    logic [IDX_W-1:0] idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = rr_ptr_reg + IDX_W'(k);
      if (!grant_valid && nonempty[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
    // No broadcast (and therefore no pop) during reset or squash.
    if (!reset || squash) begin
      grant_valid = 1'b0;
      grant_idx   = '0;
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_valid) rr_ptr_next = grant_idx + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) rr_ptr_reg <= '0;
    else        rr_ptr_reg <= rr_ptr_next;
  end

  // ---------------------------------------------------------------------
  // CDB outputs, forced to zero when idle
  // ---------------------------------------------------------------------
  always_comb begin
    cdb_valid       = grant_valid;
    cdb_tag         = '0;
    cdb_value       = '0;
    cdb_take_branch = 1'b0;
    cdb_fu_idx      = '0;
    if (grant_valid) begin
      cdb_tag         = head_tag[grant_idx];
      cdb_value       = head_value[grant_idx];
      cdb_take_branch = head_br[grant_idx];
      cdb_fu_idx      = grant_idx;
    end
  end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Testbench for cdb_broadcaster: table of per-cycle vectors plus short
// hand-written sequences for the single-result and reset corner cases.
module tb_cdb_broadcaster;

  logic         clock = 1'b0;
  logic         reset;
  logic         squash;
  logic [3:0]   fu_valid;
  logic [19:0]  fu_tag;
  logic [127:0] fu_value;
  logic [3:0]   fu_take_branch;
  logic [3:0]   fu_ready;
  logic         cdb_valid;
  logic [4:0]   cdb_tag;
  logic [31:0]  cdb_value;
  logic         cdb_take_branch;
  logic [1:0]   cdb_fu_idx;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  cdb_broadcaster #(.NUM_FU(4), .BUF_DEPTH(2), .TAG_W(5), .XLEN(32)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_value(fu_value),
    .fu_take_branch(fu_take_branch), .fu_ready(fu_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_take_branch(cdb_take_branch), .cdb_fu_idx(cdb_fu_idx)
  );

  typedef struct {
    logic        rst_n;
    logic        sq;
    logic [3:0]  v;
    logic [19:0] tags;
    logic [3:0]  br;
    logic [3:0]  rdy;
    logic        cv;
    logic [4:0]  ct;
    logic        cb;
    logic [1:0]  ci;
  } vec_t;

  localparam int NV = 31;
  vec_t vec [NV];

  // Stimulus value attached to a tag, so the value can be predicted from it.
  function automatic logic [31:0] val_of(input logic [4:0] t);
    return 32'hC0DE_0000 + {27'd0, t};
  endfunction

  function automatic vec_t mk(input logic rst_n, input logic sq, input logic [3:0] v,
                              input logic [4:0] t0, input logic [4:0] t1,
                              input logic [4:0] t2, input logic [4:0] t3,
                              input logic [3:0] br, input logic [3:0] rdy,
                              input logic cv, input logic [4:0] ct,
                              input logic cb, input logic [1:0] ci);
    vec_t r;
    r.rst_n = rst_n; r.sq = sq; r.v = v; r.tags = {t3, t2, t1, t0}; r.br = br;
    r.rdy = rdy; r.cv = cv; r.ct = ct; r.cb = cb; r.ci = ci;
    return r;
  endfunction

  task automatic apply(input logic rst_n, input logic sq, input logic [3:0] v,
                       input logic [19:0] tags, input logic [3:0] br);
    reset          = rst_n;
    squash         = sq;
    fu_valid       = v;
    fu_tag         = tags;
    fu_take_branch = br;
    for (int i = 0; i < 4; i++) fu_value[i*32 +: 32] = val_of(tags[i*5 +: 5]);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [3:0] rdy, input logic cv,
                         input logic [4:0] ct, input logic [31:0] cval,
                         input logic cb, input logic [1:0] ci);
    chk({name, ".fu_ready"},  32'(fu_ready), 32'(rdy));
    chk({name, ".cdb_valid"}, 32'(cdb_valid), 32'(cv));
    chk({name, ".cdb_tag"},   32'(cdb_tag), 32'(ct));
    chk({name, ".cdb_value"}, cdb_value, cval);
    chk({name, ".cdb_br"},    32'(cdb_take_branch), 32'(cb));
    chk({name, ".cdb_idx"},   32'(cdb_fu_idx), 32'(ci));
    $display("%s rdy=%b cdb_valid=%0d tag=%0d value=%h br=%0d idx=%0d",
             name, fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_take_branch, cdb_fu_idx);
  endtask

  initial begin
    apply(1'b0, 1'b0, 4'h0, 20'd0, 4'h0);

    //           rst sq  v      t0  t1  t2  t3  br       rdy      cv ct  cb ci
    // reset held with all units valid
    vec[0]  = mk(0, 0, 4'hF,    1,  2,  3,  4, 4'hF,    4'h0,    0, 0,  0, 0);
    vec[1]  = mk(0, 0, 4'hF,    1,  2,  3,  4, 4'hF,    4'h0,    0, 0,  0, 0);
    vec[2]  = mk(0, 0, 4'hF,    1,  2,  3,  4, 4'hF,    4'h0,    0, 0,  0, 0);
    vec[3]  = mk(1, 0, 4'h0,    0,  0,  0,  0, 4'h0,    4'hF,    0, 0,  0, 0);
    // round-robin: all four push together, drained in order 0,1,2,3
    vec[4]  = mk(1, 0, 4'hF,   10, 11, 12, 13, 4'b0101, 4'hF,    0, 0,  0, 0);
    vec[5]  = mk(1, 0, 4'h0,    0,  0,  0,  0, 4'h0,    4'hF,    1, 10, 1, 0);
    vec[6]  = mk(1, 0, 4'h0,    0,  0,  0,  0, 4'h0,    4'hF,    1, 11, 0, 1);
    vec[7]  = mk(1, 0, 4'h0,    0,  0,  0,  0, 4'h0,    4'hF,    1, 12, 1, 2);
    vec[8]  = mk(1, 0, 4'h0,    0,  0,  0,  0, 4'h0,    4'hF,    1, 13, 0, 3);
    // fairness: FU0 streams, FU3 pushes once and wins the second slot
    vec[9]  = mk(1, 0, 4'b1001, 20, 0,  0, 21, 4'b1000, 4'hF,    0, 0,  0, 0);
    vec[10] = mk(1, 0, 4'b0001, 22, 0,  0,  0, 4'h0,    4'hF,    1, 20, 0, 0);
    vec[11] = mk(1, 0, 4'b0001, 23, 0,  0,  0, 4'h0,    4'hF,    1, 21, 1, 3);
    vec[12] = mk(1, 0, 4'h0,    0,  0,  0,  0, 4'h0,    4'b1110, 1, 22, 0, 0);
    vec[13] = mk(1, 0, 4'h0,    0,  0,  0,  0, 4'h0,    4'hF,    1, 23, 0, 0);
    // backpressure: FU1 fills while others are granted, third push held
    vec[14] = mk(1, 0, 4'b1101, 40, 0, 41, 42, 4'h0,    4'hF,    0, 0,  0, 0);
    vec[15] = mk(1, 0, 4'b0010, 0, 30,  0,  0, 4'h0,    4'hF,    1, 41, 0, 2);
    vec[16] = mk(1, 0, 4'b0010, 0, 31,  0,  0, 4'h0,    4'hF,    1, 42, 0, 3);
    vec[17] = mk(1, 0, 4'b0010, 0, 32,  0,  0, 4'h0,    4'b1101, 1, 40, 0, 0);
    vec[18] = mk(1, 0, 4'b0010, 0, 32,  0,  0, 4'h0,    4'b1101, 1, 30, 0, 1);
    vec[19] = mk(1, 0, 4'b0010, 0, 32,  0,  0, 4'h0,    4'hF,    1, 31, 0, 1);
    vec[20] = mk(1, 0, 4'h0,    0,  0,  0,  0, 4'h0,    4'hF,    1, 32, 0, 1);
    // squash: FU0/FU1 loaded, squash cycle with FU2 pushing
    vec[21] = mk(1, 0, 4'b0011, 50, 51, 0,  0, 4'h0,    4'hF,    0, 0,  0, 0);
    vec[22] = mk(1, 0, 4'b0011, 52, 53, 0,  0, 4'h0,    4'hF,    1, 50, 0, 0);
    vec[23] = mk(1, 0, 4'b0001, 54, 0,  0,  0, 4'h0,    4'b1101, 1, 51, 0, 1);
    vec[24] = mk(1, 1, 4'b0100, 0,  0, 60,  0, 4'h0,    4'h0,    0, 0,  0, 0);
    vec[25] = mk(1, 0, 4'h0,    0,  0,  0,  0, 4'h0,    4'hF,    0, 0,  0, 0);
    vec[26] = mk(1, 0, 4'h0,    0,  0,  0,  0, 4'h0,    4'hF,    0, 0,  0, 0);
    // rr_ptr survived the squash (still 2): FU3 goes before FU1
    vec[27] = mk(1, 0, 4'b1010, 0, 70,  0, 71, 4'b0010, 4'hF,    0, 0,  0, 0);
    vec[28] = mk(1, 0, 4'h0,    0,  0,  0,  0, 4'h0,    4'hF,    1, 71, 0, 3);
    vec[29] = mk(1, 0, 4'h0,    0,  0,  0,  0, 4'h0,    4'hF,    1, 70, 1, 1);
    vec[30] = mk(1, 0, 4'h0,    0,  0,  0,  0, 4'h0,    4'hF,    0, 0,  0, 0);

    for (int n = 0; n < NV; n++) begin
      @(negedge clock);
      apply(vec[n].rst_n, vec[n].sq, vec[n].v, vec[n].tags, vec[n].br);
      #1;
      chk_out($sformatf("vec%0d", n), vec[n].rdy, vec[n].cv, vec[n].ct,
              vec[n].cv ? val_of(vec[n].ct) : 32'd0, vec[n].cb, vec[n].ci);
    end

    // Single result from FU2 with an explicit value (rr_ptr is 2 here).
    @(negedge clock);
    apply(1'b1, 1'b0, 4'b0100, {5'd0, 5'd7, 5'd0, 5'd0}, 4'b0100);
    fu_value[64 +: 32] = 32'hDEAD_BEEF;
    #1;
    chk_out("single.push", 4'hF, 1'b0, 5'd0, 32'd0, 1'b0, 2'd0);
    @(negedge clock);
    apply(1'b1, 1'b0, 4'h0, 20'd0, 4'h0);
    #1;
    chk_out("single.bcast", 4'hF, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1, 2'd2);
    @(negedge clock);
    #1;
    chk_out("single.idle", 4'hF, 1'b0, 5'd0, 32'd0, 1'b0, 2'd0);

    // Reset with pending data and squash asserted: reset wins, FIFOs flushed,
    // rr_ptr (3 before) returns to 0 so FU1 beats FU3 afterwards.
    @(negedge clock);
    apply(1'b1, 1'b0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd9}, 4'h0);
    #1;
    chk_out("rst.push", 4'hF, 1'b0, 5'd0, 32'd0, 1'b0, 2'd0);
    @(negedge clock);
    apply(1'b0, 1'b1, 4'h0, 20'd0, 4'h0);
    #1;
    chk_out("rst.hold", 4'h0, 1'b0, 5'd0, 32'd0, 1'b0, 2'd0);
    @(negedge clock);
    apply(1'b1, 1'b0, 4'b1010, {5'd3, 5'd0, 5'd2, 5'd0}, 4'h0);
    #1;
    chk_out("rst.release", 4'hF, 1'b0, 5'd0, 32'd0, 1'b0, 2'd0);
    @(negedge clock);
    apply(1'b1, 1'b0, 4'h0, 20'd0, 4'h0);
    #1;
    chk_out("rst.first", 4'hF, 1'b1, 5'd2, val_of(5'd2), 1'b0, 2'd1);
    @(negedge clock);
    #1;
    chk_out("rst.second", 4'hF, 1'b1, 5'd3, val_of(5'd3), 1'b0, 2'd3);
    @(negedge clock);
    #1;
    chk_out("rst.idle", 4'hF, 1'b0, 5'd0, 32'd0, 1'b0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdb_broadcaster.md
# cdb_broadcaster

Completion-side producer of the common data bus. Accepts finished results from the execute functional units, buffers them per unit, and broadcasts exactly one result per cycle to the dispatch/issue stage (RS, ROB, map table), which consume it as the CDB packet. Fair round-robin arbitration prevents unit starvation, per-unit backpressure stalls full units, and a ROB squash flushes all in-flight results.

## Interface
Parameters:
- NUM_FU, 4, number of functional-unit result ports (power of two, ≥2)
- BUF_DEPTH, 2, result FIFO entries per unit (≥1)
- TAG_W, 5, ROB tag width
- XLEN, 32, result value width

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- squash  in  1  ROB mispredict flush, synchronous
- fu_valid  in  NUM_FU  unit i presents a completed result
- fu_tag  in  NUM_FU*TAG_W  ROB tag of unit i, slice [i*TAG_W +: TAG_W]
- fu_value  in  NUM_FU*XLEN  result value of unit i
- fu_take_branch  in  NUM_FU  resolved branch taken flag of unit i
- fu_ready  out  NUM_FU  unit i may hand over a result this cycle
- cdb_valid  out  1  CDB carries a valid broadcast this cycle
- cdb_tag  out  TAG_W  broadcast ROB tag
- cdb_value  out  XLEN  broadcast value
- cdb_take_branch  out  1  broadcast branch outcome
- cdb_fu_idx  out  $clog2(NUM_FU)  source unit of the broadcast

## Operation
- Per unit: circular FIFO of BUF_DEPTH entries {tag, value, take_branch}, head/tail pointers, count 0..BUF_DEPTH.
- Push: fu_valid[i] & fu_ready[i] at a rising edge writes tail, tail wraps BUF_DEPTH-1 → 0.
- fu_ready[i] = reset & ~squash & (count[i] < BUF_DEPTH); ignores same-cycle pop (conservative). fu_valid while not ready: result not captured; unit must hold it.
- Arbiter: rr_ptr (log2 NUM_FU bits). Grant = first non-empty unit scanning rr_ptr, rr_ptr+1, … mod NUM_FU. Grant pops that head at the edge; rr_ptr ← grant+1 mod NUM_FU. No grant → rr_ptr unchanged.
- CDB outputs are combinational from granted head (no fu_* → cdb_* path). cdb_valid=0 → tag/value/take_branch/fu_idx driven 0.
- Simultaneous push and pop on the same unit: both occur; count unchanged.
- Squash: at the edge, all FIFOs emptied (count, head, tail ← 0); pushes dropped; during squash cycle cdb_valid=0, no pop; rr_ptr unchanged.
- Reset: counts/pointers 0, rr_ptr 0; during reset cycle cdb_valid=0, fu_ready=0.

## Timing
- Reset values: cdb_valid 0, cdb_tag 0, cdb_value 0, cdb_take_branch 0, cdb_fu_idx 0, fu_ready all 0 while reset=0; all 1 first cycle after release.
- Latency: result pushed at edge E appears on CDB earliest in cycle following E (1 cycle), if granted.
- Throughput: one broadcast per cycle whenever any FIFO non-empty; per-unit sustained rate 1/cycle only if sole requester.
- Worst-case wait for a non-empty head: NUM_FU-1 cycles.
- Full FIFO: fu_ready drops the cycle after the filling push, rises the cycle after a pop.
- Squash has priority over push, pop, and reset-release ordering is irrelevant (reset has priority over squash).

## Test plan
- Reset: hold reset=0 3 cycles with fu_valid=4'hF → cdb_valid=0, fu_ready=0; release → fu_ready=4'hF, cdb_valid=0.
- Single result: FU2 pushes tag 7, value 32'hDEAD_BEEF, take_branch 1 at edge E → cycle after E: cdb_valid=1, tag 7, value DEADBEEF, fu_idx 2; next cycle cdb_valid=0.
- Round-robin: all four units push one result same edge, rr_ptr=0 → broadcasts in order FU0,1,2,3 over 4 consecutive cycles; then rr_ptr=0 again.
- Fairness: FU0 pushes every cycle, FU3 pushes once → FU3 broadcast within ≤3 cycles of push; FU0 never granted twice consecutively while FU3 pending.
- Backpressure: FU1 pushes 3 results back-to-back while FU0 monopolises grants → fu_ready[1]=0 after second push; third result held, accepted after FU1's first pop; tags broadcast in push order.
- Squash: fill FU0 and FU1 to 2 entries, assert squash 1 cycle with FU2 pushing → cdb_valid=0 that cycle, no FU2 capture, all FIFOs empty next cycle, cdb_valid stays 0.
